// File: rtl/mario_pkg.sv
// Shared frame codes and mode encoding for the Mario animator and the sprite colour stage.
package mario_pkg;

  // 4-bit frame codes; 14 and 15 are never driven.
  typedef enum logic [3:0] {
    FrStand      = 4'd0,
    FrWalkLeft1  = 4'd1,
    FrWalkLeft2  = 4'd2,
    FrWalkMid    = 4'd3,
    FrWalkRight1 = 4'd4,
    FrWalkRight2 = 4'd5,
    FrFlyLeft    = 4'd6,
    FrFlyRight   = 4'd7,
    FrClamp1     = 4'd8,
    FrClamp2     = 4'd9,
    FrDie1       = 4'd10,
    FrDie2       = 4'd11,
    FrDie3       = 4'd12,
    FrDie4       = 4'd13
  } frame_e;

  typedef enum logic [2:0] {
    ModeStand = 3'd0,
    ModeWalkL = 3'd1,
    ModeWalkR = 3'd2,
    ModeFly   = 3'd3,
    ModeClimb = 3'd4,
    ModeDying = 3'd5,
    ModeDead  = 3'd6
  } mode_e;

  // Walk cycle: X1 -> X2 -> MID -> X1, direction decides where MID returns to.
  function automatic frame_e walk_next(input frame_e f, input logic left);
    case (f)
      FrWalkLeft1:  return FrWalkLeft2;
      FrWalkLeft2:  return FrWalkMid;
      FrWalkRight1: return FrWalkRight2;
      FrWalkRight2: return FrWalkMid;
      default:      return left ? FrWalkLeft1 : FrWalkRight1;
    endcase
  endfunction

endpackage

// File: rtl/mario_animator_if.sv
// Input controls and frame outputs of the Mario animator, bundled as one interface.
interface mario_animator_if;
  logic       tick;
  logic       move_left;
  logic       move_right;
  logic       airborne;
  logic       on_ladder;
  logic       climb_move;
  logic       die;
  logic [3:0] animate_state;
  logic       dead;
  logic       die_done;

  modport master (
    output tick, move_left, move_right, airborne, on_ladder, climb_move, die,
    input  animate_state, dead, die_done
  );

  modport slave (
    input  tick, move_left, move_right, airborne, on_ladder, climb_move, die,
    output animate_state, dead, die_done
  );
endinterface

// File: rtl/anim_frame_ctr.sv
// Tick counter that flags the last tick of a frame hold period of div ticks.
module anim_frame_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] div,
  output logic       tc
);

  logic [3:0] cnt_q, cnt_d;

  assign tc = (cnt_q == div - 4'd1);

  // Next count: clear wins, otherwise wrap at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? 4'd0 : cnt_q + 4'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mario_animator.sv
// Mario sprite frame sequencer: walk, fly, climb and death animations.
// Optional macro MARIO_DIE_SPIN_EN: spin DIE1..DIE3 three times before DIE4.
module mario_animator
  import mario_pkg::*;
#(
  parameter int unsigned FRAME_DIV = 4,
  parameter int unsigned DIE_DIV   = 8
) (
  input logic             clk,
  input logic             rst,
  mario_animator_if.slave bus
);

  localparam logic [3:0] FrameDivW = 4'(FRAME_DIV);
  localparam logic [3:0] DieDivW   = 4'(DIE_DIV);

`ifdef MARIO_DIE_SPIN_EN
  localparam logic [1:0] LastSpin = 2'd2;
`else
  localparam logic [1:0] LastSpin = 2'd0;
`endif

  mode_e      mode_q, mode_d, sel_mode;
  frame_e     frame_q, frame_d;
  logic       facing_left_q, facing_left_d;
  logic       die_pending_q, die_pending_d;
  logic       dead_q, dead_d;
  logic       die_done_q, die_done_d;
  logic [1:0] spin_q, spin_d;
  logic       ctr_clr, ctr_en, ctr_tc;
  logic [3:0] ctr_div;
  logic       locked;

  assign locked  = (mode_q == ModeDying) || (mode_q == ModeDead);
  assign ctr_div = (mode_q == ModeDying) ? DieDivW : FrameDivW;

  anim_frame_ctr u_ctr (
    .clk (clk),
    .rst (rst),
    .clr (ctr_clr),
    .en  (ctr_en),
    .div (ctr_div),
    .tc  (ctr_tc)
  );

  // Mode selection by priority; both directions held counts as no direction.
  always_comb begin
    sel_mode = ModeStand;
    if (die_pending_q || bus.die)                     sel_mode = ModeDying;
    else if (bus.on_ladder)                           sel_mode = ModeClimb;
    else if (bus.airborne)                            sel_mode = ModeFly;
    else if (bus.move_left && !bus.move_right)        sel_mode = ModeWalkL;
    else if (bus.move_right && !bus.move_left)        sel_mode = ModeWalkR;
  end

  // Next-state: die latches any cycle, everything else advances on tick only.
  always_comb begin
    mode_d        = mode_q;
    frame_d       = frame_q;
    facing_left_d = facing_left_q;
    die_pending_d = die_pending_q;
    dead_d        = dead_q;
    die_done_d    = 1'b0;
    spin_d        = spin_q;
    ctr_clr       = 1'b0;
    ctr_en        = 1'b0;

    if (bus.die && !locked) die_pending_d = 1'b1;

    if (bus.tick) begin
      if (mode_q == ModeDead) begin
        // Terminal: frame stays DIE4 until reset.
      end else if (mode_q == ModeDying) begin
        ctr_en = 1'b1;
        if (ctr_tc) begin
          unique case (frame_q)
            FrDie1: frame_d = FrDie2;
            FrDie2: frame_d = FrDie3;
            FrDie3: begin
              if (spin_q == LastSpin) begin
                frame_d = FrDie4;
              end else begin
                frame_d = FrDie1;
                spin_d  = spin_q + 2'd1;
              end
            end
            FrDie4: begin
              mode_d     = ModeDead;
              dead_d     = 1'b1;
              die_done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end else if (sel_mode != mode_q) begin
        mode_d  = sel_mode;
        ctr_clr = 1'b1;
        case (sel_mode)
          ModeWalkL: begin
            frame_d       = FrWalkLeft1;
            facing_left_d = 1'b1;
          end
          ModeWalkR: begin
            frame_d       = FrWalkRight1;
            facing_left_d = 1'b0;
          end
          ModeFly:   frame_d = facing_left_q ? FrFlyLeft : FrFlyRight;
          ModeClimb: frame_d = FrClamp1;
          ModeDying: begin
            frame_d       = FrDie1;
            die_pending_d = 1'b0;
            spin_d        = 2'd0;
          end
          default:   frame_d = FrStand;
        endcase
      end else begin
        case (mode_q)
          ModeWalkL, ModeWalkR: begin
            ctr_en = 1'b1;
            if (ctr_tc) frame_d = walk_next(frame_q, mode_q == ModeWalkL);
          end
          ModeClimb: begin
            // Counter and frame freeze while the climb key is released.
            if (bus.climb_move) begin
              ctr_en = 1'b1;
              if (ctr_tc) frame_d = (frame_q == FrClamp1) ? FrClamp2 : FrClamp1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q        <= ModeStand;
      frame_q       <= FrStand;
      facing_left_q <= 1'b0;
      die_pending_q <= 1'b0;
      dead_q        <= 1'b0;
      die_done_q    <= 1'b0;
      spin_q        <= 2'd0;
    end else begin
      mode_q        <= mode_d;
      frame_q       <= frame_d;
      facing_left_q <= facing_left_d;
      die_pending_q <= die_pending_d;
      dead_q        <= dead_d;
      die_done_q    <= die_done_d;
      spin_q        <= spin_d;
    end
  end

  assign bus.animate_state = frame_q;
  assign bus.dead          = dead_q;
  assign bus.die_done      = die_done_q;

endmodule
